// File: rtl/object_draw_datapath.sv
// Datapath for the view-control FSM: background scan, random object placement, sprite pixel
// counter, placed-object counts and the registered pixel bus. Optional macro: OBJ_GRID_ALIGN_EN.
module object_draw_datapath #(
    parameter int          SCR_W    = 320,
    parameter int          SCR_H    = 240,
    parameter int          Y_MIN    = 64,
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter logic [2:0]  BG_COLOR = 3'b011
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        draw_background,
    input  logic        enable_x_adder,
    input  logic        enable_y_adder,
    input  logic        load_x,
    input  logic        load_y,
    input  logic        load_color,
    input  logic        load_stone,
    input  logic        enable_c,
    input  logic        resetn_c,
    input  logic        enable_gold,
    input  logic        enable_stone,
    input  logic        resetn_gold_stone,
    input  logic        writeEn,
    output logic [8:0]  cout,
    output logic [16:0] background_cout,
    output logic [2:0]  gold_cout,
    output logic [2:0]  stone_cout,
    output logic [8:0]  x_out,
    output logic [7:0]  y_out,
    output logic [2:0]  colour_out,
    output logic        plot
);

    localparam logic [8:0] SCR_W9  = 9'(SCR_W);
    localparam logic [7:0] SCR_H8  = 8'(SCR_H);
    localparam logic [7:0] Y_MIN8  = 8'(Y_MIN);
    localparam logic [8:0] X_RANGE = 9'(SCR_W - 16);
    localparam logic [7:0] Y_RANGE = 8'(SCR_H - 16 - Y_MIN);

    logic [15:0] lfsr_q, lfsr_d;
    logic [8:0]  obj_x_q, obj_x_d;
    logic [7:0]  obj_y_q, obj_y_d;
    logic [16:0] bg_cnt_q, bg_cnt_d;
    logic [8:0]  cout_q, cout_d;
    logic [2:0]  gold_q, gold_d;
    logic [2:0]  stone_q, stone_d;
    logic        stone_sel_q, stone_sel_d;
    logic [8:0]  x_out_q, x_out_d;
    logic [7:0]  y_out_q, y_out_d;
    logic [2:0]  colour_out_q, colour_out_d;
    logic        pix_valid_q, pix_valid_d;

    logic [8:0]  x_place;
    logic [7:0]  y_place;
    logic [3:0]  col, row;
    logic        corner, border;

    // Range mapping of the current LFSR value into legal object positions.
    always_comb begin
        x_place = 9'(lfsr_q[8:0] % X_RANGE);
        y_place = Y_MIN8 + 8'(lfsr_q[7:0] % Y_RANGE);
`ifdef OBJ_GRID_ALIGN_EN
        x_place = {x_place[8:4], 4'b0000};
        y_place = {y_place[7:4], 4'b0000};
        if (y_place < Y_MIN8) begin
            y_place = y_place + 8'd16;
        end
`endif
    end

    always_comb begin
        col    = cout_q[3:0];
        row    = cout_q[7:4];
        corner = ((col == 4'd0) || (col == 4'd15)) && ((row == 4'd0) || (row == 4'd15));
        border = (col == 4'd0) || (col == 4'd15) || (row == 4'd0) || (row == 4'd15);
    end

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        if (lfsr_q == 16'd0) begin
            lfsr_d = SEED;
        end

        obj_x_d     = load_x ? x_place : obj_x_q;
        obj_y_d     = load_y ? y_place : obj_y_q;
        stone_sel_d = load_color ? load_stone : stone_sel_q;
        bg_cnt_d    = draw_background ? bg_cnt_q + 17'd1 : bg_cnt_q;

        cout_d = cout_q;
        if (!resetn_c) begin
            cout_d = 9'd0;
        end else if (enable_c && !cout_q[8]) begin
            cout_d = cout_q + 9'd1;
        end

        gold_d = gold_q;
        if (!resetn_gold_stone) begin
            gold_d = 3'd0;
        end else if (enable_gold && (gold_q != 3'd7)) begin
            gold_d = gold_q + 3'd1;
        end

        stone_d = stone_q;
        if (!resetn_gold_stone) begin
            stone_d = 3'd0;
        end else if (enable_stone && (stone_q != 3'd7)) begin
            stone_d = stone_q + 3'd1;
        end

        x_out_d      = x_out_q;
        y_out_d      = y_out_q;
        colour_out_d = colour_out_q;
        pix_valid_d  = pix_valid_q;
        if (draw_background) begin
            if (enable_x_adder) x_out_d = bg_cnt_q[8:0];
            if (enable_y_adder) y_out_d = bg_cnt_q[16:9];
            if (enable_x_adder || enable_y_adder) begin
                colour_out_d = BG_COLOR;
                pix_valid_d  = (bg_cnt_q[8:0] < SCR_W9) && (bg_cnt_q[16:9] < SCR_H8);
            end
        end else begin
            if (enable_x_adder) x_out_d = obj_x_q + {5'd0, col};
            if (enable_y_adder) y_out_d = obj_y_q + {4'd0, row};
            if (enable_x_adder || enable_y_adder) begin
                pix_valid_d = !cout_q[8] && !corner;
                if (stone_sel_d) begin
                    colour_out_d = border ? 3'b111 : 3'b101;
                end else begin
                    colour_out_d = 3'b110;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_q       <= SEED;
            obj_x_q      <= 9'd0;
            obj_y_q      <= Y_MIN8;
            stone_sel_q  <= 1'b0;
            bg_cnt_q     <= 17'd0;
            cout_q       <= 9'd0;
            gold_q       <= 3'd0;
            stone_q      <= 3'd0;
            x_out_q      <= 9'd0;
            y_out_q      <= 8'd0;
            colour_out_q <= 3'd0;
            pix_valid_q  <= 1'b0;
        end else begin
            lfsr_q       <= lfsr_d;
            obj_x_q      <= obj_x_d;
            obj_y_q      <= obj_y_d;
            stone_sel_q  <= stone_sel_d;
            bg_cnt_q     <= bg_cnt_d;
            cout_q       <= cout_d;
            gold_q       <= gold_d;
            stone_q      <= stone_d;
            x_out_q      <= x_out_d;
            y_out_q      <= y_out_d;
            colour_out_q <= colour_out_d;
            pix_valid_q  <= pix_valid_d;
        end
    end

    assign cout            = cout_q;
    assign background_cout = bg_cnt_q;
    assign gold_cout       = gold_q;
    assign stone_cout      = stone_q;
    assign x_out           = x_out_q;
    assign y_out           = y_out_q;
    assign colour_out      = colour_out_q;
    // The strobe from the FSM carries the pixel registered on the previous step.
    assign plot            = writeEn & pix_valid_q;

endmodule
